keypad_digit_capture: RTL

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and produces the two hex digits shown on the dual seven-segment display. Each accepted keypress shifts the previous newest digit into `left` and loads the new key into `right`. The block sits directly upstream of the seven-segment multiplexer and replaces the DIP-switch `left`/`right` inputs. It also feeds the same digits to the LED sum decoder.

---
 rtl/keypad_digit_capture.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   presses and releases, and presents the last two accepted keys as a pair
//   of hex digits for the dual seven-segment display.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high
//   rows[3:0]  keypad row pins, active-low, asynchronous to clk
//   cols[3:0]  keypad column drives, active-low, exactly one bit low
//   left[3:0]  older digit (previous value of right)
//   right[3:0] newest digit
//   key_code   hex value of the last accepted key
//   key_valid  one-cycle pulse in the cycle a key is accepted
module keypad_digit_capture #(
  parameter int unsigned SCAN_DIV     = 4800,
  parameter int unsigned DEBOUNCE_CNT = 120000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] left,
  output logic [3:0] right,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      rows_meta_q, rs_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      left_q, right_q, code_q;
  logic            valid_q;
  logic            commit;
  logic [1:0]      row_sel;
  logic [3:0]      commit_code;

  // Row/column position to key legend.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // State and datapath registers; rows pass through a 2-flop synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_q <= '1;
      rs_q        <= '1;
      state_q     <= SCAN;
      dwell_q     <= '0;
      cnt_q       <= '0;
      col_q       <= '0;
      pat_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      rows_meta_q <= rows;
      rs_q        <= rows_meta_q;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      valid_q     <= commit;
      if (commit) begin
        left_q  <= right_q;
        right_q <= commit_code;
        code_q  <= commit_code;
      end
    end
  end

  // Lowest-index low row of the captured pattern wins.
  always_comb begin
    if (!pat_q[0])      row_sel = 2'd0;
    else if (!pat_q[1]) row_sel = 2'd1;
    else if (!pat_q[2]) row_sel = 2'd2;
    else                row_sel = 2'd3;
    commit_code = key_map(row_sel, col_q);
  end

  // cnt_q serves both as the press-debounce count and the release count;
  // it is cleared on entry to each use.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    pat_d   = pat_q;
    commit  = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (rs_q != 4'hF) begin
            pat_d   = rs_q;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d   = col_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs_q != pat_q) begin
          state_d = SCAN;
          dwell_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (rs_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    cols      = ~(4'b0001 << col_q);
    left      = left_q;
    right     = right_q;
    key_code  = code_q;
    key_valid = valid_q;
  end

endmodule
